// File: rtl/act_compressor.sv
// act_compressor: zero-run compression of one activation row for the PE AFIFO.
// Output word = {flag, low}; flag=0 -> low is a nonzero activation,
// flag=1 -> low is a zero-run length in 1..MAX_ZERO_RUN.
// Build option: define ACT_COMPRESS_EN to enable zero-run compression;
// without it every accepted activation (zero included) is forwarded as
// {1'b0, act_in} one cycle later.
module act_compressor #(
  parameter int activation_width     = 16,
  parameter int compressed_act_width = activation_width + 1,
  parameter int MAX_ZERO_RUN         = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [activation_width-1:0]     act_in,
  input  logic                            act_valid,
  input  logic                            act_last,
  output logic                            act_ready,
  input  logic                            out_ready,
  output logic [compressed_act_width-1:0] compressed_act_out,
  output logic                            compressed_act_write
);

  logic [compressed_act_width-1:0] out_q, out_d;
  logic                            wr_q, wr_d;
  logic                            accept;

  function automatic logic [compressed_act_width-1:0] make_word(
    input logic                        flag,
    input logic [activation_width-1:0] low
  );
    logic [compressed_act_width-1:0] w;
    w = '0;
    w[compressed_act_width-1] = flag;
    w[activation_width-1:0]   = low;
    return w;
  endfunction

`ifdef ACT_COMPRESS_EN
  localparam int RUN_W = $clog2(MAX_ZERO_RUN + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZRUN = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  localparam logic [RUN_W:0] MAX_RUN = (RUN_W + 1)'(MAX_ZERO_RUN);
  localparam logic [RUN_W:0] ONE     = (RUN_W + 1)'(1);

  logic [1:0]                  state_q, state_d;
  logic [RUN_W-1:0]            run_q, run_d;
  logic [activation_width-1:0] val_q, val_d;
  logic [RUN_W:0]              run_inc;
  logic                        is_zero;
  logic                        run_full;

  assign act_ready = out_ready && (state_q != PEND);
  assign accept    = act_valid && act_ready;
  assign is_zero   = (act_in == '0);
  assign run_inc   = {1'b0, run_q} + ONE;
  assign run_full  = (run_inc == MAX_RUN);

  // Next-state / emit decision; nothing moves while out_ready is low.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    val_d   = val_q;
    out_d   = out_q;
    wr_d    = 1'b0;
    if (out_ready) begin
      if (state_q == PEND) begin
        // Drain the value that arrived behind a run word.
        out_d   = make_word(1'b0, val_q);
        wr_d    = 1'b1;
        state_d = IDLE;
      end else if (accept) begin
        if (is_zero) begin
          if (run_full || act_last) begin
            out_d   = make_word(1'b1, activation_width'(run_inc));
            wr_d    = 1'b1;
            run_d   = '0;
            state_d = IDLE;
          end else begin
            run_d   = run_inc[RUN_W-1:0];
            state_d = ZRUN;
          end
        end else if (state_q == ZRUN) begin
          // Close the run first; the value follows next cycle from PEND.
          out_d   = make_word(1'b1, activation_width'(run_q));
          wr_d    = 1'b1;
          val_d   = act_in;
          run_d   = '0;
          state_d = PEND;
        end else begin
          out_d   = make_word(1'b0, act_in);
          wr_d    = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  // Compression state: FSM, run counter and the parked value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      val_q   <= val_d;
    end
  end
`else
  logic unused_cfg;

  assign act_ready  = out_ready;
  assign accept     = act_valid && out_ready;
  assign unused_cfg = act_last & (MAX_ZERO_RUN > 0);

  // Bypass: forward every accepted activation unchanged.
  always_comb begin
    out_d = out_q;
    wr_d  = 1'b0;
    if (accept) begin
      out_d = make_word(1'b0, act_in);
      wr_d  = 1'b1;
    end
  end
`endif

  // Output word and write strobe registers (one-cycle latency).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      wr_q  <= wr_d;
    end
  end

  assign compressed_act_out   = out_q;
  assign compressed_act_write = wr_q;

endmodule
